// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target endpoint, all pins oversampled in the clk domain.
// Ports: clk/rstb; spi_clk, spi_csb, spi_mosi in; spi_miso, spi_miso_oe out;
//   tx_data/tx_valid/tx_ready one-entry TX holding register; rx_data/rx_valid/rx_ready
//   one-entry RX holding register; busy; sticky rx_overrun/tx_underrun, cleared by flag_clr.
module spi_target #(
    parameter logic [7:0]  FILL_BYTE   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       spi_clk,
    input  logic       spi_csb,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       rx_overrun,
    output logic       tx_underrun,
    input  logic       flag_clr
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    logic [SYNC_STAGES-1:0] csb_q;
    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   csb_dly_q;
    logic                   sck_dly_q;
    logic                   armed_q;

    logic csb_s;
    logic sck_s;
    logic mosi_s;

    assign csb_s  = csb_q[SYNC_STAGES-1];
    assign sck_s  = sck_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    // fill_q tracks when the chain holds real pin samples rather than reset
    // values; armed_q then requires CS to be seen high before any cs_fall is
    // honoured, so CS already low at reset release never starts a transfer.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            csb_q     <= '1;
            sck_q     <= '0;
            mosi_q    <= '0;
            fill_q    <= '0;
            csb_dly_q <= 1'b1;
            sck_dly_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            csb_q     <= {csb_q[SYNC_STAGES-2:0], spi_csb};
            sck_q     <= {sck_q[SYNC_STAGES-2:0], spi_clk};
            mosi_q    <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
            fill_q    <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            csb_dly_q <= csb_s;
            sck_dly_q <= sck_s;
            armed_q   <= armed_q | (fill_q[SYNC_STAGES-1] & csb_s);
        end
    end

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       tx_full_q, tx_full_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       ovr_q, ovr_d;
    logic       unf_q, unf_d;

    logic       cs_fall;
    logic       cs_rise;
    logic       act;
    logic       sck_rise;
    logic       sck_fall;
    logic       byte_start;
    logic       byte_done;
    logic       tx_wr;
    logic [7:0] rx_byte;
    logic       ovr_set;
    logic       unf_set;

    assign cs_fall    = armed_q & (state_q == IDLE) & csb_dly_q & ~csb_s;
    assign cs_rise    = ~csb_dly_q & csb_s;
    assign act        = (state_q == ACTIVE) & ~csb_s;
    assign sck_rise   = act & sck_s & ~sck_dly_q;
    assign sck_fall   = act & ~sck_s & sck_dly_q;
    assign byte_start = cs_fall | (sck_fall & (bit_cnt_q == 3'd0));
    assign byte_done  = sck_rise & (bit_cnt_q == 3'd7);
    assign rx_byte    = {rx_shift_q[6:0], mosi_s};
    assign tx_wr      = tx_valid & ~tx_full_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_hold_d  = tx_hold_q;
        tx_full_d  = tx_full_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        ovr_set    = 1'b0;
        unf_set    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (sck_rise) begin
            rx_shift_d = rx_byte;
            bit_cnt_d  = bit_cnt_q + 3'd1;
        end

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        // A pop in the completion cycle frees the slot for the new byte.
        if (byte_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end

        if (tx_wr) begin
            tx_hold_d = tx_data;
            tx_full_d = 1'b1;
        end

        // A write landing on a byte start with the register empty bypasses
        // straight into the shifter and leaves the register empty.
        if (byte_start) begin
            if (tx_full_q) begin
                tx_shift_d = tx_hold_q;
                tx_full_d  = 1'b0;
            end else if (tx_valid) begin
                tx_shift_d = tx_data;
                tx_full_d  = 1'b0;
            end else begin
                tx_shift_d = FILL_BYTE;
                unf_set    = 1'b1;
            end
        end else if (sck_fall) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end

        ovr_d = ovr_set | (ovr_q & ~flag_clr);
        unf_d = unf_set | (unf_q & ~flag_clr);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'h00;
            tx_hold_q  <= 8'h00;
            tx_full_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            tx_hold_q  <= tx_hold_d;
            tx_full_q  <= tx_full_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            unf_q      <= unf_d;
        end
    end

    assign spi_miso    = tx_shift_q[7];
    assign spi_miso_oe = (state_q == ACTIVE);
    assign busy        = (state_q == ACTIVE);
    assign tx_ready    = ~tx_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = ovr_q;
    assign tx_underrun = unf_q;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: randomized host/MMU stimulus against a transaction-level model.
// Checks reset state, byte transfer, bursts, overrun, abort and coincident events.
module tb_spi_target;

    localparam int H = 8;

    logic       clk;
    logic       rstb;
    logic       spi_clk;
    logic       spi_csb;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       rx_overrun;
    logic       tx_underrun;
    logic       flag_clr;

    spi_target dut (
        .clk         (clk),
        .rstb        (rstb),
        .spi_clk     (spi_clk),
        .spi_csb     (spi_csb),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .busy        (busy),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun),
        .flag_clr    (flag_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] mo_b [4];
    logic [7:0] mi_b [4];
    logic [7:0] ex_b [4];
    bit         wr_b [4];
    logic [7:0] wr_d [4];
    bit         cs_wr;
    logic [7:0] cs_wr_d;
    bit         auto_pop;
    int         pop_hit;
    bit         chk_lat;
    logic [7:0] rx_seen [$];

    bit         m_tx_full;
    logic [7:0] m_tx_hold;
    bit         m_rx_full;
    logic [7:0] m_rx_data;
    bit         m_ovr;
    bit         m_unf;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_tx_full = 0;
        m_tx_hold = 8'h00;
        m_rx_full = 0;
        m_rx_data = 8'h00;
        m_ovr     = 0;
        m_unf     = 0;
    endtask

    task automatic m_byte_start(input int i);
        if (m_tx_full) begin
            ex_b[i]   = m_tx_hold;
            m_tx_full = 0;
        end else if (i == 0 && cs_wr) begin
            ex_b[i] = cs_wr_d;
        end else begin
            ex_b[i] = 8'hFF;
            m_unf   = 1;
        end
    endtask

    task automatic m_byte_done(input logic [7:0] d);
        if (m_rx_full) begin
            m_ovr = 1;
        end else begin
            m_rx_full = 1;
            m_rx_data = d;
        end
    endtask

    task automatic clear_cfg();
        for (int k = 0; k < 4; k++) begin
            wr_b[k] = 0;
            wr_d[k] = 8'h00;
            ex_b[k] = 8'h00;
            mi_b[k] = 8'h00;
        end
        cs_wr    = 0;
        auto_pop = 0;
        pop_hit  = -1;
        chk_lat  = 0;
    endtask

    task automatic tx_write(input logic [7:0] d);
        check("tx_ready_wr", tx_ready, 1'b1);
        tx_valid = 1'b1;
        tx_data  = d;
        step(1);
        tx_valid  = 1'b0;
        m_tx_full = 1;
        m_tx_hold = d;
    endtask

    task automatic rx_pop();
        if (m_rx_full) begin
            check("pop_valid", rx_valid, 1'b1);
            check("pop_data", rx_data, m_rx_data);
            rx_ready = 1'b1;
            step(1);
            rx_ready  = 1'b0;
            m_rx_full = 0;
        end
    endtask

    task automatic do_flag_clr();
        flag_clr = 1'b1;
        step(1);
        flag_clr = 1'b0;
        m_ovr = 0;
        m_unf = 0;
        step(1);
        check("ovr_clr", rx_overrun, 1'b0);
        check("unf_clr", tx_underrun, 1'b0);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_rxv"}, rx_valid, m_rx_full);
        check({tag, "_rxd"}, rx_data, m_rx_data);
        check({tag, "_ovr"}, rx_overrun, m_ovr);
        check({tag, "_unf"}, tx_underrun, m_unf);
        check({tag, "_txr"}, tx_ready, !m_tx_full);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic host_xfer(input int nbits);
        int i;
        int j;
        step(1);
        spi_csb  = 1'b0;
        spi_mosi = mo_b[0][7];
        m_byte_start(0);
        for (int c = 0; c < H; c++) begin
            if (c == 2) begin
                check("busy_pre", busy, 1'b0);
                if (cs_wr) begin
                    tx_valid = 1'b1;
                    tx_data  = cs_wr_d;
                end
            end
            if (c == 3) begin
                tx_valid = 1'b0;
                check("busy", busy, 1'b1);
                check("miso_oe", spi_miso_oe, 1'b1);
                check("miso_first", spi_miso, ex_b[0][7]);
            end
            if (c == 4 && cs_wr) check("cswr_txr", tx_ready, 1'b1);
            step(1);
        end
        for (int b = 0; b < nbits; b++) begin
            i = b / 8;
            j = b % 8;
            mi_b[i][7-j] = spi_miso;
            spi_clk = 1'b1;
            if (j == 7) begin
                if (pop_hit == i) begin
                    check("hit_oldv", rx_valid, 1'b1);
                    check("hit_oldd", rx_data, m_rx_data);
                    m_rx_full = 0;
                end
                m_byte_done(mo_b[i]);
            end
            for (int c = 0; c < H; c++) begin
                if (j == 7 && chk_lat && c == 2)
                    check("rxv_early", rx_valid, 1'b0);
                if (j == 7 && chk_lat && c == 3)
                    check("rxv_lat", rx_valid, 1'b1);
                if (j == 7 && pop_hit == i && c == 2) rx_ready = 1'b1;
                if (j == 7 && pop_hit == i && c == 3) rx_ready = 1'b0;
                if (j == 7 && auto_pop && c == 4) begin
                    check("apop_v", rx_valid, m_rx_full);
                    if (m_rx_full) begin
                        check("apop_d", rx_data, m_rx_data);
                        rx_seen.push_back(rx_data);
                        rx_ready  = 1'b1;
                        m_rx_full = 0;
                    end
                end
                if (c == 5) rx_ready = 1'b0;
                if (j == 3 && wr_b[i] && c == 1) begin
                    check("txr_pre", tx_ready, 1'b1);
                    tx_valid  = 1'b1;
                    tx_data   = wr_d[i];
                    m_tx_full = 1;
                    m_tx_hold = wr_d[i];
                end
                if (j == 3 && wr_b[i] && c == 2) begin
                    tx_valid = 1'b0;
                    check("txr_post", tx_ready, 1'b0);
                end
                step(1);
            end
            spi_clk = 1'b0;
            if (b == nbits - 1) begin
                spi_csb = 1'b1;
            end else begin
                spi_mosi = mo_b[(b+1)/8][7-((b+1)%8)];
                if (j == 7) m_byte_start(i + 1);
            end
            step(H);
        end
        step(H);
        for (int k = 0; k < nbits / 8; k++)
            check("miso_byte", mi_b[k], ex_b[k]);
    endtask

    initial begin
        int n;
        int nbits;
        rstb     = 1'b0;
        spi_clk  = 1'b0;
        spi_csb  = 1'b1;
        spi_mosi = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        flag_clr = 1'b0;
        m_reset();
        clear_cfg();

        step(2);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_oe", spi_miso_oe, 1'b0);
        check("rst_txr", tx_ready, 1'b1);
        check("rst_rxd", rx_data, 8'h00);
        check("rst_rxv", rx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovr", rx_overrun, 1'b0);
        check("rst_unf", tx_underrun, 1'b0);
        rstb = 1'b1;
        step(4);

        tx_write(8'hA5);
        mo_b[0] = 8'h3C;
        chk_lat = 1;
        host_xfer(8);
        check("single_rx", rx_data, 8'h3C);
        check_state("single");
        rx_pop();

        clear_cfg();
        tx_write(8'h11);
        wr_b[0] = 1;
        wr_d[0] = 8'h22;
        mo_b[0] = 8'h01;
        mo_b[1] = 8'h02;
        mo_b[2] = 8'h03;
        auto_pop = 1;
        rx_seen.delete();
        host_xfer(24);
        check("burst_b2", ex_b[2], 8'hFF);
        check("burst_unf", tx_underrun, 1'b1);
        check("burst_cnt", rx_seen.size(), 3);
        for (int k = 0; k < rx_seen.size() && k < 3; k++)
            check("burst_ord", rx_seen[k], mo_b[k]);
        check_state("burst");
        do_flag_clr();

        clear_cfg();
        mo_b[0] = 8'hDE;
        mo_b[1] = 8'hAD;
        host_xfer(16);
        check("ovr_rxd", rx_data, 8'hDE);
        check("ovr_set", rx_overrun, 1'b1);
        check_state("ovr");
        do_flag_clr();
        rx_pop();

        clear_cfg();
        tx_write(8'h77);
        wr_b[0] = 1;
        wr_d[0] = 8'h99;
        mo_b[0] = 8'hFF;
        host_xfer(5);
        check("abort_rxv", rx_valid, 1'b0);
        check_state("abort");
        clear_cfg();
        mo_b[0] = 8'h5A;
        host_xfer(8);
        check("after_rxd", rx_data, 8'h5A);
        check_state("after");

        clear_cfg();
        cs_wr   = 1;
        cs_wr_d = 8'hC3;
        pop_hit = 0;
        mo_b[0] = 8'h96;
        host_xfer(8);
        check("sim_tx", mi_b[0], 8'hC3);
        check("sim_rx", rx_data, 8'h96);
        check_state("sim");
        rx_pop();

        step(1);
        spi_csb = 1'b0;
        step(H);
        rstb = 1'b0;
        step(2);
        rstb = 1'b1;
        m_reset();
        step(6);
        check("rlow_busy", busy, 1'b0);
        check("rlow_oe", spi_miso_oe, 1'b0);
        for (int k = 0; k < 16; k++) begin
            spi_clk = ~spi_clk;
            step(H);
        end
        spi_csb = 1'b1;
        step(H);
        check_state("rlow");

        for (int t = 0; t < 12; t++) begin
            clear_cfg();
            n = $urandom_range(1, 3);
            nbits = n * 8;
            if ($urandom % 4 == 0) nbits = nbits - $urandom_range(1, 7);
            for (int k = 0; k < n; k++) begin
                mo_b[k] = 8'($urandom);
                wr_b[k] = $urandom % 2;
                wr_d[k] = 8'($urandom);
            end
            if (!m_tx_full && $urandom % 2) tx_write(8'($urandom));
            if (!m_tx_full && $urandom % 2) begin
                cs_wr   = 1;
                cs_wr_d = 8'($urandom);
            end
            auto_pop = $urandom % 2;
            host_xfer(nbits);
            check_state("rand");
            if ($urandom % 3 == 0) do_flag_clr();
            if ($urandom % 2) rx_pop();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

SPI mode-0 target (peripheral) endpoint. It is the receive-side counterpart of the SPI master that drives the display: an external SPI host clocks bytes in on `spi_mosi` while the block returns bytes on `spi_miso`. All SPI pins are oversampled in the `clk` domain. Received bytes are exposed to the MMU through a one-entry valid/ready holding register, and bytes to transmit are accepted the same way.

## Interface
- `FILL_BYTE`, default 8'hFF: byte shifted out when no TX byte is queued at a byte boundary.
- `SYNC_STAGES`, default 2: synchronizer depth for `spi_clk`, `spi_csb` and `spi_mosi`. Minimum 2.

- `clk` input 1: system clock. All logic is on the rising edge.
- `rstb` input 1: synchronous, active-low reset.
- `spi_clk` input 1: host SPI clock. Asynchronous to `clk`.
- `spi_csb` input 1: host chip select, active low. Asynchronous to `clk`.
- `spi_mosi` input 1: host-to-target data. Asynchronous to `clk`.
- `spi_miso` output 1: target-to-host data. Valid only while `spi_miso_oe`=1.
- `spi_miso_oe` output 1: tristate enable for the pad. Equals the synchronized `~spi_csb`.
- `tx_data` input 8: next byte to send.
- `tx_valid` input 1: TX write request.
- `tx_ready` output 1: TX holding register empty.
- `rx_data` output 8: last received byte.
- `rx_valid` output 1: RX holding register full.
- `rx_ready` input 1: consumer pops RX.
- `busy` output 1: a transaction is in progress (synchronized CS asserted).
- `rx_overrun` output 1: sticky flag. Cleared by `flag_clr`.
- `tx_underrun` output 1: sticky flag. Cleared by `flag_clr`.
- `flag_clr` input 1: clears both sticky flags.

## Operation
- **Synchronization and edge detection**
  - Each SPI input passes through `SYNC_STAGES` flops. Edges are then detected against a one-flop-delayed copy.
  - Events: `cs_fall`, `cs_rise`, `sck_rise`, `sck_fall`. `sck_*` events count only while the synchronized CS is low.
- **States**
  - IDLE: CS high. `busy`=0, `spi_miso_oe`=0.
  - ACTIVE: entered on `cs_fall`, left on `cs_rise`. On leaving, `bit_cnt` returns to 0.
- **Bit counter**: `bit_cnt` is 3 bits.
  - Each `sck_rise` shifts the synchronized MOSI into `rx_shift` LSB (MSB-first) and increments `bit_cnt`, wrapping 7→0.
  - On the rise that wraps, the byte is complete.
- **Byte complete**
  - If `rx_valid`=0, or `rx_ready`=1 in the same cycle: `rx_data` ← the full byte (`{rx_shift[6:0], mosi}`), `rx_valid`=1.
  - Otherwise: the new byte is discarded, the old byte is kept, and `rx_overrun` is set.
- **TX load**: `tx_shift` is loaded at every byte start. A byte start is `cs_fall`, or `sck_fall` with `bit_cnt`==0.
  - Source is the TX holding register if full; the register then empties.
  - Otherwise the source is `FILL_BYTE`, and `tx_underrun` is set.
  - Any other `sck_fall` shifts `tx_shift` left by 1.
  - `spi_miso` = `tx_shift[7]`.
- **TX holding register**: `tx_valid & tx_ready` writes `tx_data`.
  - If a write and a byte-start load occur in the same cycle with the register empty, the new byte goes straight to `tx_shift`, `tx_ready` stays 1, and no underrun is flagged.
- **RX pop**: `rx_valid & rx_ready` clears `rx_valid`. `rx_data` holds its value.
- **CS rise mid-byte**
  - The partial RX byte is dropped; `rx_valid` is unchanged.
  - The partially sent TX byte is lost and is not requeued.
  - The TX holding register keeps its contents.
- **Flag priority**: `flag_clr` in the same cycle as a set event leaves the flag set (set wins).

## Timing
- **Reset values**: `spi_miso`=0, `spi_miso_oe`=0, `tx_ready`=1, `rx_data`=8'h00, `rx_valid`=0, `busy`=0, `rx_overrun`=0, `tx_underrun`=0. Internal shift registers and `bit_cnt` reset to 0. All synchronizer flops reset to their idle values: CS=1, SCK=0, MOSI=0.
- A `rstb` assertion mid-transaction aborts it. After release the block waits for a fresh `cs_fall`; CS already low at release does not start a transaction.
- **Latency from pin edge to effect**, with `SYNC_STAGES`=2:
  - `cs_fall` takes effect (`busy`, `spi_miso_oe`, first MISO bit) 3 `clk` cycles after the pin edge.
  - `rx_valid` rises 3 cycles after the 8th SCK pin rising edge.
  - The MISO update lands 3 cycles after the SCK pin falling edge.
  - In general, latency is `SYNC_STAGES`+1.
- **SPI clock limits**: `spi_clk` high and low phases must each be ≥ `SYNC_STAGES`+3 `clk` cycles. The CS-low to first-SCK-rise setup must also be ≥ `SYNC_STAGES`+3 `clk` cycles.
- **Host sampling**: MISO is valid to the host for sampling on the next SCK rise.
- `tx_ready` deasserts the cycle after an accepted write.

## Test plan
- **Reset check**: `rstb`=0 for 2 cycles → all outputs equal their reset values, and `tx_ready`=1.
- **Single byte**: preload TX 8'hA5. Host sends 8'h3C (SCK period 16 `clk`) → host reads 8'hA5; `rx_data`=8'h3C; `rx_valid` rises 3 cycles after the 8th SCK rise; no flags set.
- **Three-byte burst**: TX queued 8'h11, 8'h22 on time, third byte not queued. Host sends 8'h01, 8'h02, 8'h03 and pops each → host reads 11, 22, FF; `tx_underrun`=1; all three RX bytes are seen in order.
- **Overrun**: host sends 8'hDE then 8'hAD with no pop → `rx_data` stays 8'hDE and `rx_overrun`=1. After `flag_clr` the flag is 0.
- **Abort**: CS rises after 5 bits of 8'hFF → `rx_valid` stays 0. The next full transfer of 8'h5A is received correctly, starting at bit 0.
- **Simultaneous events**:
  - A `tx_valid` write coinciding with `cs_fall` while the holding register is empty → the written byte goes out first, with no underrun.
  - A pop coinciding with byte completion → the new byte is latched with no overrun.
